clock_time_counter: RTL and testbench
=====================================

// Module: clock_time_counter
// PURPOSE
//   BCD time-of-day register for the desk clock: HH:MM:SS in 24-hour format.
//   Sits directly downstream of the sysclk fractional divider; advances one
//   second per divider overflow strobe and accepts user set-button pulses.
//   Feeds the display driver through registered BCD digits and update strobes.
// PARAMETERS
//   INIT_HH   8'h12  reset hours value, packed BCD, 00..23
//   INIT_MM   8'h00  reset minutes value, packed BCD, 00..59
//   INIT_SS   8'h00  reset seconds value, packed BCD, 00..59
//   - Non-BCD or out-of-range values are illegal.
//   - Sim-only initial check: $fatal if any value is illegal.
// PORTS
//   i_sysclk     in   1  system clock (~50MHz); all logic rises on this edge
//   i_reset      in   1  synchronous reset, active-high
//   i_en         in   1  count/set enable; when low, time is frozen
//   i_1hz_stb    in   1  1-cycle second strobe (divider overflow pulse)
//   i_set_hr     in   1  1-cycle pulse: hours +1
//   i_set_min    in   1  1-cycle pulse: minutes +1, seconds cleared
//   o_hours      out  6  BCD hours   {tens[1:0], ones[3:0]}
//   o_minutes    out  7  BCD minutes {tens[2:0], ones[3:0]}
//   o_seconds    out  7  BCD seconds {tens[2:0], ones[3:0]}
//   o_changed    out  1  1-cycle pulse: an output digit changed this cycle
//   o_day_stb    out  1  1-cycle pulse: tick-driven wrap 23:59:59 -> 00:00:00
// BEHAVIOUR
//   Reset (i_reset high at a clock edge, regardless of i_en):
//     - o_hours/o_minutes/o_seconds load INIT_HH/INIT_MM/INIT_SS, width-truncated.
//     - o_changed=0 and o_day_stb=0.
//     - A strobe coincident with reset is lost.
//   All outputs are registered. Latency: input pulse at edge N -> new value after edge N.
//   i_en low:
//     - All inputs except reset are ignored; strobes are dropped, not queued.
//     - o_changed and o_day_stb are 0.
//   Tick (i_1hz_stb, no set pulse active):
//     - Seconds ones digit 0..9 carries into seconds tens 0..5; 59 wraps to 00.
//     - Seconds wrap carries +1 into minutes, same rules; 59 wraps to 00.
//     - Minutes wrap carries +1 into hours; hours 23 wraps to 00.
//     - Hours ones digit rolls 9 -> 0 into tens; at tens=2, ones 3 -> 00.
//     - A full day wrap asserts o_day_stb the same cycle the outputs show 00:00:00.
//   Set pulses have priority over the tick: any set pulse active -> tick dropped that cycle.
//     - i_set_min: minutes +1, wrap 59->00 with no carry into hours; seconds <= 00.
//     - i_set_hr: hours +1, wrap 23->00; minutes and seconds untouched.
//     - Both set pulses in one cycle: both applied, no cross-carry.
//     - Set pulses never assert o_day_stb.
//   o_changed asserts for 1 cycle after any tick or set update that is applied.
//     - It also asserts when a set leaves digits numerically equal (e.g. seconds already 00).
//     - It is not asserted on reset.
//   Held (multi-cycle) inputs count once per cycle.
//     - Debounce and edge detection are upstream.
//   Only legal BCD states are reachable; no illegal-state recovery is required.
// TESTING
//   1. Reset with defaults -> 12:00:00, o_changed=0, o_day_stb=0; hold reset plus ticks -> unchanged.
//   2. INIT 23:59:58, two ticks -> 23:59:59 then 00:00:00 with o_day_stb=1 for exactly 1 cycle.
//   3. From 09:59:59, one tick -> 10:00:00; from 19:59:59 -> 20:00:00 (hours tens carry).
//   4. 10:59:30 + i_set_min -> 10:00:00 (no hour carry); 23:xx + i_set_hr -> 00:xx, o_day_stb=0.
//   5. i_set_min coincident with i_1hz_stb at 01:02:03 -> 01:03:00 (tick dropped), o_changed=1.
//   6. i_en=0 with 5 ticks and set pulses -> time frozen, no pulses; i_en=1, one tick -> +1s.

Source files
------------

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - BCD HH:MM:SS time-of-day counter with tick, set pulses and day strobe
module clock_time_counter #(
    parameter logic [7:0] INIT_HH = 8'h12,
    parameter logic [7:0] INIT_MM = 8'h00,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic       i_sysclk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_1hz_stb,
    input  logic       i_set_hr,
    input  logic       i_set_min,
    output logic [5:0] o_hours,
    output logic [6:0] o_minutes,
    output logic [6:0] o_seconds,
    output logic       o_changed,
    output logic       o_day_stb
);

    function automatic bit bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
    endfunction

    if (!bcd_ok(INIT_HH, 8'h23) || !bcd_ok(INIT_MM, 8'h59) || !bcd_ok(INIT_SS, 8'h59)) begin : g_bad_init
        $fatal(1, "clock_time_counter: INIT_HH/INIT_MM/INIT_SS must be legal BCD time");
    end

    function automatic logic [6:0] inc_sexa(input logic [6:0] v);
        if (v == 7'h59)
            return 7'h00;
        else if (v[3:0] == 4'd9)
            return {v[6:4] + 3'd1, 4'd0};
        else
            return {v[6:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] inc_hours(input logic [5:0] v);
        if (v == 6'h23)
            return 6'h00;
        else if (v[3:0] == 4'd9)
            return {v[5:4] + 2'd1, 4'd0};
        else
            return {v[5:4], v[3:0] + 4'd1};
    endfunction

    logic [5:0] r_hours;
    logic [6:0] r_minutes;
    logic [6:0] r_seconds;
    logic       r_changed;
    logic       r_day_stb;

    logic       w_set;
    logic       w_tick;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_day_wrap;
    logic [5:0] w_hours_nx;
    logic [6:0] w_minutes_nx;
    logic [6:0] w_seconds_nx;

    // Any set pulse wins over the second tick in the same cycle.
    assign w_set      = i_en && (i_set_hr || i_set_min);
    assign w_tick     = i_en && i_1hz_stb && !(i_set_hr || i_set_min);
    assign w_sec_wrap = (r_seconds == 7'h59);
    assign w_min_wrap = (r_minutes == 7'h59);
    assign w_day_wrap = w_tick && w_sec_wrap && w_min_wrap && (r_hours == 6'h23);

    always_comb begin
        w_hours_nx   = r_hours;
        w_minutes_nx = r_minutes;
        w_seconds_nx = r_seconds;
        if (w_set) begin
            if (i_set_min) begin
                w_minutes_nx = inc_sexa(r_minutes);
                w_seconds_nx = 7'h00;
            end
            if (i_set_hr)
                w_hours_nx = inc_hours(r_hours);
        end else if (w_tick) begin
            w_seconds_nx = inc_sexa(r_seconds);
            if (w_sec_wrap) begin
                w_minutes_nx = inc_sexa(r_minutes);
                if (w_min_wrap)
                    w_hours_nx = inc_hours(r_hours);
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_hours   <= INIT_HH[5:0];
            r_minutes <= INIT_MM[6:0];
            r_seconds <= INIT_SS[6:0];
            r_changed <= 1'b0;
            r_day_stb <= 1'b0;
        end else begin
            r_hours   <= w_hours_nx;
            r_minutes <= w_minutes_nx;
            r_seconds <= w_seconds_nx;
            r_changed <= w_set || w_tick;
            r_day_stb <= w_day_wrap;
        end
    end

    assign o_hours   = r_hours;
    assign o_minutes = r_minutes;
    assign o_seconds = r_seconds;
    assign o_changed = r_changed;
    assign o_day_stb = r_day_stb;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - self-checking bench for clock_time_counter against an integer time model
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic       set_hr = 1'b0;
    logic       set_min = 1'b0;
    logic [5:0] hours;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       changed;
    logic       day_stb;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: plain integers for the time of day plus expected pulses.
    int m_h = 12, m_m = 0, m_s = 0;
    bit m_changed = 1'b0, m_day = 1'b0;

    always #10 clk = ~clk;

    clock_time_counter u_dut (
        .i_sysclk  (clk),
        .i_reset   (reset),
        .i_en      (en),
        .i_1hz_stb (tick),
        .i_set_hr  (set_hr),
        .i_set_min (set_min),
        .o_hours   (hours),
        .o_minutes (minutes),
        .o_seconds (seconds),
        .o_changed (changed),
        .o_day_stb (day_stb)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [31:0] model_time();
        return (to_bcd(m_h) << 14) | (to_bcd(m_m) << 7) | to_bcd(m_s);
    endfunction

    function automatic logic [31:0] dut_time();
        return {12'd0, hours, minutes, seconds};
    endfunction

    task automatic model_step(input bit r, input bit e, input bit t, input bit sh, input bit sm);
        int secs;
        m_changed = 1'b0;
        m_day     = 1'b0;
        if (r) begin
            m_h = 12; m_m = 0; m_s = 0;
        end else if (e && (sh || sm)) begin
            if (sm) begin
                m_m = (m_m + 1) % 60;
                m_s = 0;
            end
            if (sh)
                m_h = (m_h + 1) % 24;
            m_changed = 1'b1;
        end else if (e && t) begin
            secs = m_h * 3600 + m_m * 60 + m_s + 1;
            m_day = (secs == 86400);
            secs = secs % 86400;
            m_h = secs / 3600;
            m_m = (secs / 60) % 60;
            m_s = secs % 60;
            m_changed = 1'b1;
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit t, input bit sh, input bit sm);
        reset = r; en = e; tick = t; set_hr = sh; set_min = sm;
        @(posedge clk);
        #1;
        model_step(r, e, t, sh, sm);
        check("time", dut_time(), model_time());
        check("changed", 32'(changed), 32'(m_changed));
        check("day_stb", 32'(day_stb), 32'(m_day));
        reset = 1'b0; tick = 1'b0; set_hr = 1'b0; set_min = 1'b0;
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < (h + 12) % 24; i++) cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < m; i++) cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < s; i++) cyc(0, 1, 1, 0, 0);
    endtask

    initial begin
        // Reset state, then reset held over ticks and sets.
        cyc(1, 0, 0, 0, 0);
        check("reset_time", dut_time(), {12'd0, 6'h12, 7'h00, 7'h00});
        check("reset_changed", 32'(changed), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, i[0], i[1]);
        check("reset_hold", dut_time(), {12'd0, 6'h12, 7'h00, 7'h00});

        // Day wrap.
        goto_time(23, 59, 58);
        cyc(0, 1, 1, 0, 0);
        check("pre_wrap", dut_time(), {12'd0, 6'h23, 7'h59, 7'h59});
        check("pre_wrap_day", 32'(day_stb), 32'd0);
        cyc(0, 1, 1, 0, 0);
        check("wrap_time", dut_time(), 32'd0);
        check("wrap_day", 32'(day_stb), 32'd1);
        cyc(0, 1, 0, 0, 0);
        check("wrap_day_once", 32'(day_stb), 32'd0);
        check("idle_changed", 32'(changed), 32'd0);

        // Hours tens carry.
        goto_time(9, 59, 59);
        cyc(0, 1, 1, 0, 0);
        check("carry_10", dut_time(), {12'd0, 6'h10, 7'h00, 7'h00});
        goto_time(19, 59, 59);
        cyc(0, 1, 1, 0, 0);
        check("carry_20", dut_time(), {12'd0, 6'h20, 7'h00, 7'h00});

        // Set pulses: no cross-carry, no day strobe.
        goto_time(10, 59, 30);
        cyc(0, 1, 0, 0, 1);
        check("set_min_wrap", dut_time(), {12'd0, 6'h10, 7'h00, 7'h00});
        goto_time(23, 15, 7);
        cyc(0, 1, 0, 1, 0);
        check("set_hr_wrap", dut_time(), {12'd0, 6'h00, 7'h15, 7'h07});
        check("set_hr_noday", 32'(day_stb), 32'd0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        check("set_min_zero_sec_changed", 32'(changed), 32'd1);

        // Set beats tick.
        goto_time(1, 2, 3);
        cyc(0, 1, 1, 0, 1);
        check("set_over_tick", dut_time(), {12'd0, 6'h01, 7'h03, 7'h00});
        check("set_over_tick_chg", 32'(changed), 32'd1);
        cyc(0, 1, 1, 1, 1);
        check("both_sets", dut_time(), {12'd0, 6'h02, 7'h04, 7'h00});

        // Disabled: frozen, strobes dropped.
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, i[0], ~i[0]);
        check("frozen", dut_time(), {12'd0, 6'h02, 7'h04, 7'h00});
        check("frozen_changed", 32'(changed), 32'd0);
        cyc(0, 1, 1, 0, 0);
        check("resume", dut_time(), {12'd0, 6'h02, 7'h04, 7'h01});

        // Randomized traffic near a wrap and from arbitrary points.
        goto_time(23, 58, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 29) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
